// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef logic [7:0] byte_t;

    localparam int DROP_CNT_W = 16;

    // Head-register control: EMPTY means no byte is presented on the output.
    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } head_state_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte streams into and out of the UART receive FIFO.
interface uart_rx_fifo_if;
    import uart_pkg::*;

    // Valid/ready: a byte moves on a rising edge where valid && ready are both high;
    // the source holds data stable while valid && !ready, and valid never waits on ready.
    byte_t in_data;
    logic  in_valid;
    logic  in_ready;
    byte_t out_data;
    logic  out_valid;
    logic  out_ready;

    // master: UART byte source plus downstream consumer; slave: the FIFO.
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/fifo_ram.sv
// DEPTH x 8 storage: synchronous write, asynchronous read, no reset.
module fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  byte_t                    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output byte_t                    rdata
);

    byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver, with overflow accounting.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int AF_LEVEL       = DEPTH - 2,
    parameter bit DROP_WHEN_FULL = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       clear_overflow,
    uart_rx_fifo_if.slave              bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       overflow,
    output logic [DROP_CNT_W-1:0]      drop_count,
    output head_state_t                fsm_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    byte_t         head;
    byte_t         ram_rdata;
    head_state_t   state_next;

    logic full, push, pop, drop;
    logic ram_empty, ram_we, head_from_in, head_from_ram;

    // The head byte lives in its own register; count includes it, so the RAM
    // holds count-1 bytes while HOLD and the RAM read port always points at the next byte.
    always_comb begin
        full          = (count == CW'(DEPTH));
        push          = bus.in_valid && !full;
        pop           = (fsm_state == HOLD) && bus.out_ready;
        drop          = DROP_WHEN_FULL && bus.in_valid && full;
        ram_empty     = (count <= CW'(1));
        head_from_in  = push && ((fsm_state == EMPTY) || (pop && ram_empty));
        head_from_ram = pop && !ram_empty;
        ram_we        = push && !head_from_in && !flush;

        state_next = fsm_state;
        case (fsm_state)
            EMPTY:   if (push) state_next = HOLD;
            HOLD:    if (pop && (count == CW'(1)) && !push) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
        if (flush) state_next = EMPTY;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fsm_state <= EMPTY;
        else        fsm_state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (ram_we)        wr_ptr <= wr_ptr + AW'(1);
            if (head_from_ram) rd_ptr <= rd_ptr + AW'(1);
            if (head_from_in)       head <= bus.in_data;
            else if (head_from_ram) head <= ram_rdata;
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    // Clearing wins over a drop in the same cycle; flush leaves the accounting alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + DROP_CNT_W'(1);
        end
    end

    fifo_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (bus.in_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    assign bus.in_ready  = DROP_WHEN_FULL ? 1'b1 : !full;
    assign bus.out_valid = (fsm_state == HOLD);
    assign bus.out_data  = head;
    assign almost_full   = (count >= CW'(AF_LEVEL));

endmodule
